// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types for the TPU datapath blocks.
//   byte_type             signed 8-bit quantised value
//   word_type             signed 32-bit accumulator value
//   accumulator_addr_type row address into the accumulator register file
//   activation_type       activation applied before requantisation
//   act_state_type        activation_unit sequencer states
package tpu_pkg;

    localparam int ACCUMULATOR_ADDR_WIDTH = 8;
    localparam int ACT_FIFO_DEPTH = 2;

    typedef logic signed [7:0]  byte_type;
    typedef logic signed [31:0] word_type;
    typedef logic [ACCUMULATOR_ADDR_WIDTH-1:0] accumulator_addr_type;

    typedef enum logic {
        NONE,
        RELU
    } activation_type;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } act_state_type;

    // Next row address, wrapping from depth-1 back to row 0.
    function automatic accumulator_addr_type next_row_addr(input accumulator_addr_type addr,
                                                           input int depth);
        if (int'(addr) >= depth - 1) begin
            return '0;
        end
        return addr + accumulator_addr_type'(1);
    endfunction

endpackage

// File: rtl/activation_lane.sv
// activation_lane: combinational activate / round / saturate for one lane.
//   acc     in  signed 32-bit accumulator value
//   act_sel in  NONE passes through, RELU clamps negatives to zero
//   shift   in  requantisation right-shift (0..31), round-half-up
//   result  out saturated signed 8-bit value
module activation_lane
    import tpu_pkg::*;
(
    input  word_type       acc,
    input  activation_type act_sel,
    input  logic [4:0]     shift,
    output byte_type       result
);

    word_type           activated;
    logic signed [32:0] bias;
    logic signed [32:0] rounded;
    logic signed [32:0] shifted;

    // The rounding bias is added in 33 bits so that a large positive
    // accumulator cannot wrap negative before the shift.
    always_comb begin
        activated = acc;
        if (act_sel == RELU && acc < 0) begin
            activated = '0;
        end
        bias = '0;
        if (shift != 5'd0) begin
            bias[shift - 5'd1] = 1'b1;
        end
        rounded = {activated[31], activated} + bias;
        shifted = rounded >>> shift;
        if (shifted > 33'sd127) begin
            result = 8'sd127;
        end else if (shifted < -33'sd128) begin
            result = -8'sd128;
        end else begin
            result = shifted[7:0];
        end
    end

endmodule

// File: rtl/activation_unit.sv
// activation_unit: streams accumulator rows through activation and
// requantisation into a 2-entry output FIFO with valid/ready handshake.
//   clk, rst            clock; asynchronous active-low reset
//   start               one-cycle job request (honoured only in IDLE)
//   start_addr          first accumulator row of the job
//   row_count           number of rows in the job (0 = empty job)
//   act_sel, shift      activation and requantisation shift for the job
//   acc_read_addr       register_file read address (holds when idle)
//   acc_data            register_file data, valid one cycle after address
//   out_valid/out_ready row handshake; out_data per-lane bytes
//   out_last            marks the final row of the job
//   busy                job in progress; done pulses once at job end
module activation_unit
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH   = 4,
    parameter int REGISTER_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  accumulator_addr_type start_addr,
    input  accumulator_addr_type row_count,
    input  activation_type       act_sel,
    input  logic [4:0]           shift,
    output accumulator_addr_type acc_read_addr,
    input  word_type             acc_data [MATRIX_WIDTH],
    output logic                 out_valid,
    input  logic                 out_ready,
    output byte_type             out_data [MATRIX_WIDTH],
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    act_state_type        state_q, state_d;
    accumulator_addr_type next_addr;
    accumulator_addr_type reads_left;
    activation_type       act_q;
    logic [4:0]           shift_q;
    logic                 inflight;
    logic                 inflight_last;

    byte_type             fifo_data [ACT_FIFO_DEPTH][MATRIX_WIDTH];
    logic                 fifo_last [ACT_FIFO_DEPTH];
    logic [1:0]           fifo_count;

    byte_type             lane_result [MATRIX_WIDTH];

    logic                 accept;
    logic                 pop;
    logic                 issue;
    logic                 last_issue;
    logic                 drain_finish;
    logic                 done_d;
    logic                 wr_idx;
    logic [1:0]           credit_used;

    for (genvar g = 0; g < MATRIX_WIDTH; g++) begin : g_lane
        activation_lane u_lane (
            .acc     (acc_data[g]),
            .act_sel (act_q),
            .shift   (shift_q),
            .result  (lane_result[g])
        );
    end

    assign out_valid = (fifo_count != 2'd0);
    assign out_last  = out_valid && fifo_last[0];
    assign out_data  = fifo_data[0];

    assign accept = (state_q == IDLE) && start;
    assign pop    = out_valid && out_ready;

    // Slots already spoken for once this cycle's pop is credited; counting
    // the pop is what lets a new read issue every cycle while draining.
    assign credit_used = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign issue       = (state_q == RUN) && (reads_left != '0) && (credit_used < 2'd2);
    assign last_issue  = issue && (reads_left == accumulator_addr_type'(1));

    assign drain_finish = (state_q == DRAIN) && !inflight &&
                          ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));
    assign done_d       = (accept && row_count == '0) || drain_finish;

    // An incoming row lands behind whatever survives this cycle's pop.
    assign wr_idx = (fifo_count != {1'b0, pop});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && row_count != '0) state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (drain_finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // busy stays up through the done cycle, so it is released one edge
    // after the sequencer has already returned to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done          <= 1'b0;
            busy          <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            acc_read_addr <= '0;
            next_addr     <= '0;
            reads_left    <= '0;
            act_q         <= NONE;
            shift_q       <= '0;
        end else begin
            done          <= done_d;
            busy          <= (state_d != IDLE) || drain_finish;
            inflight      <= issue;
            inflight_last <= last_issue;
            if (accept) begin
                next_addr  <= accumulator_addr_type'(int'(start_addr) % REGISTER_DEPTH);
                reads_left <= row_count;
                act_q      <= act_sel;
                shift_q    <= shift;
            end
            if (issue) begin
                acc_read_addr <= next_addr;
                next_addr     <= next_row_addr(next_addr, REGISTER_DEPTH);
                reads_left    <= reads_left - accumulator_addr_type'(1);
            end
        end
    end

    // Head-of-queue is always slot 0 so out_data never moves while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_count <= '0;
            for (int e = 0; e < ACT_FIFO_DEPTH; e++) begin
                fifo_last[e] <= 1'b0;
                for (int i = 0; i < MATRIX_WIDTH; i++) begin
                    fifo_data[e][i] <= '0;
                end
            end
        end else begin
            if (pop) begin
                fifo_last[0] <= fifo_last[1];
                for (int i = 0; i < MATRIX_WIDTH; i++) begin
                    fifo_data[0][i] <= fifo_data[1][i];
                end
            end
            if (inflight) begin
                fifo_last[wr_idx] <= inflight_last;
                for (int i = 0; i < MATRIX_WIDTH; i++) begin
                    fifo_data[wr_idx][i] <= lane_result[i];
                end
            end
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit: directed self-checking bench for activation_unit.
// A combinational register_file model presents row data for the address
// currently on acc_read_addr; outputs are sampled 1 time unit after each
// rising edge and compared against hand-computed values.
module tb_activation_unit;
    import tpu_pkg::*;

    localparam int MATRIX_WIDTH   = 4;
    localparam int REGISTER_DEPTH = 4;

    logic                 clk;
    logic                 rst;
    logic                 start;
    accumulator_addr_type start_addr;
    accumulator_addr_type row_count;
    activation_type       act_sel;
    logic [4:0]           shift;
    accumulator_addr_type acc_read_addr;
    word_type             acc_data [MATRIX_WIDTH];
    logic                 out_valid;
    logic                 out_ready;
    byte_type             out_data [MATRIX_WIDTH];
    logic                 out_last;
    logic                 busy;
    logic                 done;

    word_type             mem [REGISTER_DEPTH][MATRIX_WIDTH];

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    activation_unit #(
        .MATRIX_WIDTH   (MATRIX_WIDTH),
        .REGISTER_DEPTH (REGISTER_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_addr    (start_addr),
        .row_count     (row_count),
        .act_sel       (act_sel),
        .shift         (shift),
        .acc_read_addr (acc_read_addr),
        .acc_data      (acc_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data for the address driven this cycle is what the DUT samples at
    // the next rising edge.
    always_comb begin
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            acc_data[i] = mem[int'(acc_read_addr) % REGISTER_DEPTH][i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_row(input string tag, input logic signed [31:0] value,
                             input logic last);
        check_output({tag, " valid"}, {31'd0, out_valid}, 32'sd1);
        check_output({tag, " last"}, {31'd0, out_last}, {31'd0, last});
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            check_output($sformatf("%s lane%0d", tag, i), out_data[i], value);
        end
    endtask

    // Pulses start for one cycle; returns observing the cycle after start.
    task automatic apply_stimulus(input accumulator_addr_type addr,
                                  input accumulator_addr_type count,
                                  input activation_type act, input logic [4:0] sh);
        start      = 1'b1;
        start_addr = addr;
        row_count  = count;
        act_sel    = act;
        shift      = sh;
        step();
        start = 1'b0;
    endtask

    initial begin
        word_type row_vals [4];
        row_vals = '{32'sd100, -32'sd100, 32'sd300, -32'sd300};
        for (int r = 0; r < REGISTER_DEPTH; r++) begin
            for (int i = 0; i < MATRIX_WIDTH; i++) begin
                mem[r][i] = row_vals[r];
            end
        end

        rst        = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        row_count  = '0;
        act_sel    = NONE;
        shift      = '0;
        out_ready  = 1'b1;
        step();
        step();

        $display("[TB] reset state");
        check_output("rst valid", {31'd0, out_valid}, 32'sd0);
        check_output("rst busy", {31'd0, busy}, 32'sd0);
        check_output("rst done", {31'd0, done}, 32'sd0);
        check_output("rst last", {31'd0, out_last}, 32'sd0);
        check_output("rst addr", {24'd0, acc_read_addr}, 32'sd0);
        check_output("rst data0", out_data[0], 32'sd0);
        rst = 1'b1;
        step();

        $display("[TB] RELU shift 1, rows 0..3");
        apply_stimulus(8'd0, 8'd4, RELU, 5'd1);
        check_output("t1 busy c1", {31'd0, busy}, 32'sd1);
        check_output("t1 valid c1", {31'd0, out_valid}, 32'sd0);
        step();
        check_output("t1 addr c2", {24'd0, acc_read_addr}, 32'sd0);
        check_output("t1 valid c2", {31'd0, out_valid}, 32'sd0);
        step();
        check_row("t1 row0", 32'sd50, 1'b0);
        check_output("t1 addr c3", {24'd0, acc_read_addr}, 32'sd1);
        step();
        check_row("t1 row1", 32'sd0, 1'b0);
        step();
        check_row("t1 row2", 32'sd127, 1'b0);
        step();
        check_row("t1 row3", 32'sd0, 1'b1);
        check_output("t1 done early", {31'd0, done}, 32'sd0);
        step();
        check_output("t1 done", {31'd0, done}, 32'sd1);
        check_output("t1 busy at done", {31'd0, busy}, 32'sd1);
        check_output("t1 valid after", {31'd0, out_valid}, 32'sd0);
        step();
        check_output("t1 done clear", {31'd0, done}, 32'sd0);
        check_output("t1 busy clear", {31'd0, busy}, 32'sd0);

        $display("[TB] NONE shift 0, back-to-back");
        apply_stimulus(8'd0, 8'd4, NONE, 5'd0);
        step();
        check_output("t2 valid c2", {31'd0, out_valid}, 32'sd0);
        step();
        check_row("t2 row0", 32'sd100, 1'b0);
        step();
        check_row("t2 row1", -32'sd100, 1'b0);
        step();
        check_row("t2 row2", 32'sd127, 1'b0);
        step();
        check_row("t2 row3", -32'sd128, 1'b1);
        step();
        check_output("t2 done", {31'd0, done}, 32'sd1);

        $display("[TB] address wrap from row 3");
        step();
        apply_stimulus(8'd3, 8'd3, NONE, 5'd0);
        step();
        check_output("t3 addr0", {24'd0, acc_read_addr}, 32'sd3);
        step();
        check_output("t3 addr1", {24'd0, acc_read_addr}, 32'sd0);
        check_row("t3 row0", -32'sd128, 1'b0);
        step();
        check_output("t3 addr2", {24'd0, acc_read_addr}, 32'sd1);
        check_row("t3 row1", 32'sd100, 1'b0);
        step();
        check_row("t3 row2", -32'sd100, 1'b1);
        step();
        check_output("t3 done", {31'd0, done}, 32'sd1);

        $display("[TB] consumer stall");
        step();
        apply_stimulus(8'd0, 8'd4, NONE, 5'd0);
        step();
        step();
        check_row("t4 row0", 32'sd100, 1'b0);
        step();
        check_row("t4 row1", -32'sd100, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_row($sformatf("t4 stall%0d", k), -32'sd100, 1'b0);
            check_output($sformatf("t4 stall%0d addr", k), {24'd0, acc_read_addr}, 32'sd2);
        end
        out_ready = 1'b1;
        step();
        check_row("t4 row2", 32'sd127, 1'b0);
        check_output("t4 addr resume", {24'd0, acc_read_addr}, 32'sd3);
        step();
        check_row("t4 row3", -32'sd128, 1'b1);
        step();
        check_output("t4 done", {31'd0, done}, 32'sd1);
        check_output("t4 valid after", {31'd0, out_valid}, 32'sd0);

        $display("[TB] empty job and ignored start");
        step();
        apply_stimulus(8'd1, 8'd0, NONE, 5'd0);
        check_output("t5 busy", {31'd0, busy}, 32'sd0);
        check_output("t5 done", {31'd0, done}, 32'sd1);
        check_output("t5 valid", {31'd0, out_valid}, 32'sd0);
        step();
        check_output("t5 done clear", {31'd0, done}, 32'sd0);
        check_output("t5 valid c2", {31'd0, out_valid}, 32'sd0);
        check_output("t5 busy c2", {31'd0, busy}, 32'sd0);
        apply_stimulus(8'd0, 8'd2, NONE, 5'd0);
        apply_stimulus(8'd2, 8'd4, RELU, 5'd1);
        check_output("t5 addr ignored", {24'd0, acc_read_addr}, 32'sd0);
        step();
        check_row("t5 row0", 32'sd100, 1'b0);
        step();
        check_row("t5 row1", -32'sd100, 1'b1);
        step();
        check_output("t5 job done", {31'd0, done}, 32'sd1);
        step();
        check_output("t5 idle valid", {31'd0, out_valid}, 32'sd0);
        check_output("t5 idle busy", {31'd0, busy}, 32'sd0);

        $display("[TB] reset mid-job");
        apply_stimulus(8'd0, 8'd4, NONE, 5'd0);
        step();
        step();
        check_row("t6 row0", 32'sd100, 1'b0);
        step();
        check_row("t6 row1", -32'sd100, 1'b0);
        rst = 1'b0;
        #1;
        check_output("t6 rst valid", {31'd0, out_valid}, 32'sd0);
        check_output("t6 rst busy", {31'd0, busy}, 32'sd0);
        check_output("t6 rst done", {31'd0, done}, 32'sd0);
        check_output("t6 rst last", {31'd0, out_last}, 32'sd0);
        check_output("t6 rst addr", {24'd0, acc_read_addr}, 32'sd0);
        check_output("t6 rst data", out_data[0], 32'sd0);
        step();
        rst = 1'b1;
        step();
        check_output("t6 held valid", {31'd0, out_valid}, 32'sd0);
        apply_stimulus(8'd2, 8'd2, RELU, 5'd1);
        step();
        check_output("t6 addr", {24'd0, acc_read_addr}, 32'sd2);
        step();
        check_row("t6 new row0", 32'sd127, 1'b0);
        step();
        check_row("t6 new row1", 32'sd0, 1'b1);
        step();
        check_output("t6 done", {31'd0, done}, 32'sd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
